// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch (read-only) and data
// (read/write) requesters. Data wins by default; a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ready,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wstrb,
  output logic            dm_ready,
  output logic [DW-1:0]   dm_rdata,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);
  localparam int SW = DW/8;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mreq_t;

  state_t        state, state_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic [7:0]    tcnt, tcnt_nxt;
  mreq_t         mreq, mreq_nxt;
  logic          mem_req_nxt, if_ready_nxt, dm_ready_nxt, err_nxt;
  logic [DW-1:0] if_rdata_nxt, dm_rdata_nxt;
  logic          force_if;

  assign force_if = if_req && (starve_cnt == SMAX);

  always_comb begin
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    tcnt_nxt     = tcnt;
    mreq_nxt     = mreq;
    mem_req_nxt  = mem_req;
    if_ready_nxt = 1'b0;
    dm_ready_nxt = 1'b0;
    err_nxt      = 1'b0;
    if_rdata_nxt = if_rdata;
    dm_rdata_nxt = dm_rdata;
    case (state)
      IDLE: begin
        if (dm_req && !force_if) begin
          state_nxt   = GNT_DM;
          mem_req_nxt = 1'b1;
          tcnt_nxt    = '0;
          mreq_nxt    = '{we: dm_we, addr: dm_addr, wdata: dm_wdata,
                          wstrb: dm_we ? dm_wstrb : '0};
          if (if_req && starve_cnt != SMAX) starve_nxt = starve_cnt + 4'd1;
        end else if (if_req) begin
          state_nxt   = GNT_IF;
          mem_req_nxt = 1'b1;
          tcnt_nxt    = '0;
          starve_nxt  = '0;
          mreq_nxt    = '{we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0};
        end
      end
      GNT_IF, GNT_DM: begin
        // ack wins over a timeout landing in the same cycle
        if (mem_ack || tcnt == TLAST) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          err_nxt     = !mem_ack;
          if (state == GNT_IF) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = mem_ack ? mem_rdata : '0;
          end else begin
            dm_ready_nxt = 1'b1;
            dm_rdata_nxt = (mem_ack && !mreq.we) ? mem_rdata : '0;
          end
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tcnt       <= '0;
      mreq       <= '0;
      mem_req    <= 1'b0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      tcnt       <= tcnt_nxt;
      mreq       <= mreq_nxt;
      mem_req    <= mem_req_nxt;
      if_ready   <= if_ready_nxt;
      dm_ready   <= dm_ready_nxt;
      err        <= err_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_rdata   <= dm_rdata_nxt;
    end
  end

  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;
  assign mem_wstrb = mreq.wstrb;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder model plus a scoreboard of
// expected ready pulses (port, data, err) checked in completion order.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        if_ready, dm_ready, err;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          req_cycles = 0;
  logic        ack_en = 1'b1;
  logic        stray_ack = 1'b0;
  logic        last_we;
  logic [3:0]  last_wstrb;
  logic [31:0] last_addr, last_wdata;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic dm, input logic [31:0] rdata, input logic e);
    exp_t x;
    x.dm = dm; x.rdata = rdata; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_ready(input string tag, output logic was_dm, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(if_ready || dm_ready) && cycles < 200);
    n_chk++;
    assert (if_ready || dm_ready) else begin
      n_fail++;
      $error("FAIL %s no ready within %0d cycles", tag, cycles);
    end
    was_dm = dm_ready;
  endtask

  // memory model: acks in the first cycle it sees mem_req
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (mem_req) req_cycles++;
      if ((mem_req && ack_en) || stray_ack) begin
        mem_ack = 1'b1;
        mem_rdata = mem_fn(mem_addr);
        if (mem_req) begin
          last_we = mem_we; last_wstrb = mem_wstrb;
          last_addr = mem_addr; last_wdata = mem_wdata;
        end
      end
    end
  end

  // scoreboard: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && (if_ready || dm_ready)) begin
      exp_t e;
      chk("one_ready_at_a_time", {if_ready, dm_ready} == 2'b11, 0);
      chk("ready_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_port", dm_ready, e.dm);
        chk("sb_rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
        chk("sb_err", err, e.err);
      end
    end else if (reset) begin
      if (err) chk("err_without_ready", err, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic was_dm, saw_dm;
    int   cyc, gap;

    reset = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {mem_req, mem_we, if_ready, dm_ready, err}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    reset = 1'b1;
    @(negedge clk);

    // lone fetch
    req_cycles = 0;
    if_addr = 32'h100; if_req = 1;
    push(0, 32'h0050_0093, 0);
    wait_ready("fetch", was_dm, cyc);
    if_req = 0;
    chk("fetch_latency", cyc, 2);
    chk("fetch_req_cycles", req_cycles, 1);
    chk("fetch_mem_addr", last_addr, 32'h100);
    chk("fetch_we_wstrb", {last_we, last_wstrb}, 0);
    @(negedge clk);
    chk("fetch_rdata_hold", if_rdata, 32'h0050_0093);

    // conflict: DM first, IF right after DM's RESP
    @(negedge clk);
    if_addr = 32'h200; dm_addr = 32'h2000; dm_we = 0;
    if_req = 1; dm_req = 1;
    push(1, mem_fn(32'h2000), 0);
    push(0, mem_fn(32'h200), 0);
    wait_ready("conflict_1", was_dm, cyc);
    chk("conflict_dm_first", was_dm, 1);
    dm_req = 0;
    wait_ready("conflict_2", was_dm, gap);
    chk("conflict_if_second", was_dm, 0);
    chk("conflict_gap", gap, 3);
    if_req = 0;
    repeat (2) @(negedge clk);

    // starvation: DM held every slot, IF forced in after 4 DM grants, twice
    if_addr = 32'h300; dm_addr = 32'h2000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1, mem_fn(32'h2000), 0);
      push(0, mem_fn(32'h300), 0);
    end
    if_req = 1; dm_req = 1;
    for (int k = 0; k < 10; k++) begin
      wait_ready("starve", saw_dm, cyc);
      chk("starve_slot_gap", cyc, (k == 0) ? 2 : 3);
    end
    chk("starve_last_is_if", saw_dm, 0);
    if_req = 0; dm_req = 0;
    repeat (2) @(negedge clk);

    // store
    dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
    dm_req = 1;
    push(1, 32'h0, 0);
    wait_ready("store", was_dm, cyc);
    dm_req = 0; dm_we = 0;
    chk("store_we_wstrb", {last_we, last_wstrb}, 5'b1_0011);
    chk("store_addr", last_addr, 32'h40);
    chk("store_wdata", last_wdata, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);

    // timeout: memory never acks
    ack_en = 0; req_cycles = 0;
    dm_addr = 32'h80; dm_req = 1;
    push(1, 32'h0, 1);
    wait_ready("timeout", was_dm, cyc);
    dm_req = 0;
    chk("timeout_req_cycles", req_cycles, 8);
    chk("timeout_err", {dm_ready, err}, 2'b11);
    @(negedge clk);
    chk("timeout_req_dropped", mem_req, 0);
    stray_ack = 1;
    repeat (2) @(negedge clk);
    stray_ack = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_ack_ignored", {mem_req, if_ready, dm_ready, err}, 0);
    end

    // reset while in GNT_DM
    dm_addr = 32'h2000; dm_req = 1;
    repeat (3) @(negedge clk);
    chk("pre_reset_in_grant", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", {mem_req, mem_we, if_ready, dm_ready, err}, 0);
    chk("midrst_payload", {mem_addr, mem_wstrb}, 0);
    chk("midrst_rdata", {if_rdata, dm_rdata}, 0);
    @(negedge clk);
    dm_req = 0; ack_en = 1;
    reset = 1'b1;
    @(negedge clk);
    if_addr = 32'h100; if_req = 1;
    push(0, 32'h0050_0093, 0);
    wait_ready("post_reset_fetch", was_dm, cyc);
    if_req = 0;
    chk("post_reset_latency", cyc, 2);
    repeat (3) @(negedge clk);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
